// File: rtl/matmul_drain.sv
// matmul_drain: walks the A x C result RAM in row-major order and streams each word out through a 2-entry skid buffer.
// Define MATMUL_DRAIN_REQUANT_EN to narrow each word to a rounded, saturated signed Q_BITS value.
module matmul_drain #(
    parameter int A        = 16,
    parameter int C        = 24,
    parameter int OUT_BITS = 32,
    parameter int Q_BITS   = 8,
    localparam int L       = A * C,
    localparam int AW      = $clog2(L),
`ifdef MATMUL_DRAIN_REQUANT_EN
    localparam int OUT_W   = Q_BITS
`else
    localparam int OUT_W   = OUT_BITS
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4:0]          shift,
    output logic [AW-1:0]       m3_rd_addr,
    input  logic [OUT_BITS-1:0] m3_rd_data,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [AW:0]   L_CNT     = (AW + 1)'(L);
    localparam logic [AW-1:0] LAST_ADDR = AW'(L - 1);

    state_t           state_r;
    logic [AW:0]      issued_r;
    logic             inflight_r;
    logic [OUT_W-1:0] skid_data_r;
    logic             skid_valid_r;
    logic             skid_last_r;

    logic             pop_s;
    logic             issue_s;
    logic [2:0]       occ_s;
    logic [OUT_W-1:0] wr_data_s;
    logic             wr_last_s;

`ifdef MATMUL_DRAIN_REQUANT_EN
    localparam logic signed [OUT_BITS:0] Q_MAX = (OUT_BITS + 1)'((2 ** (Q_BITS - 1)) - 1);
    localparam logic signed [OUT_BITS:0] Q_MIN = (OUT_BITS + 1)'(-(2 ** (Q_BITS - 1)));

    // Round-half-up arithmetic shift, evaluated one bit wider so the rounding add cannot overflow.
    function automatic logic [Q_BITS-1:0] requant(input logic [OUT_BITS-1:0] x, input logic [4:0] sh);
        logic signed [OUT_BITS:0] rnd;
        logic signed [OUT_BITS:0] sum;
        logic signed [OUT_BITS:0] q;
        if (sh != 5'd0) begin
            rnd = (OUT_BITS + 1)'(1) << (sh - 5'd1);
        end else begin
            rnd = '0;
        end
        sum = $signed({x[OUT_BITS-1], x}) + rnd;
        q   = sum >>> sh;
        if (q > Q_MAX) begin
            requant = {1'b0, {(Q_BITS - 1){1'b1}}};
        end else if (q < Q_MIN) begin
            requant = {1'b1, {(Q_BITS - 1){1'b0}}};
        end else begin
            requant = q[Q_BITS-1:0];
        end
    endfunction

    assign wr_data_s = requant(m3_rd_data, shift);
`else
    logic unused_cfg;
    assign unused_cfg = (^shift) ^ (Q_BITS > 0);
    assign wr_data_s  = m3_rd_data;
`endif

    // The word on m3_rd_data belongs to the address currently presented.
    assign wr_last_s = (m3_rd_addr == LAST_ADDR);

    // Read credit: counts the pop happening this cycle so the stream sustains one word per cycle.
    always_comb begin
        pop_s   = out_valid & out_ready;
        occ_s   = 3'(out_valid) + 3'(skid_valid_r) + 3'(inflight_r) - 3'(pop_s);
        issue_s = 1'b0;
        if ((state_r == STREAM) && (issued_r < L_CNT) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Control FSM, read issue and the head/skid pair that forms the output FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            m3_rd_addr   <= '0;
            issued_r     <= '0;
            inflight_r   <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            skid_data_r  <= '0;
            skid_valid_r <= 1'b0;
            skid_last_r  <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                m3_rd_addr <= issued_r[AW-1:0];
                issued_r   <= issued_r + (AW + 1)'(1);
            end

            // Head only moves when empty or popped, so a stalled beat stays frozen.
            if (!out_valid || pop_s) begin
                if (skid_valid_r) begin
                    out_data     <= skid_data_r;
                    out_last     <= skid_last_r;
                    out_valid    <= 1'b1;
                    skid_valid_r <= inflight_r;
                    skid_data_r  <= wr_data_s;
                    skid_last_r  <= wr_last_s;
                end else if (inflight_r) begin
                    out_data  <= wr_data_s;
                    out_last  <= wr_last_s;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            end else if (inflight_r) begin
                skid_data_r  <= wr_data_s;
                skid_last_r  <= wr_last_s;
                skid_valid_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_r    <= STREAM;
                        busy       <= 1'b1;
                        m3_rd_addr <= '0;
                        issued_r   <= '0;
                    end
                end
                STREAM: begin
                    if (pop_s && out_last) begin
                        state_r <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_drain.sv
// Directed bench for matmul_drain with a 2x3 result RAM; works with or without MATMUL_DRAIN_REQUANT_EN.
module tb_matmul_drain;

`ifdef MATMUL_DRAIN_REQUANT_EN
    localparam int OUT_W = 8;
`else
    localparam int OUT_W = 32;
`endif

    typedef struct {
        logic [31:0]      word;
        logic [OUT_W-1:0] exp;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [4:0]       shift;
    logic [2:0]       m3_rd_addr;
    logic [31:0]      m3_rd_data;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
    logic             done;

    logic [31:0] mem [0:7];
    logic [31:0] exp_data [0:5];
    logic [31:0] got_data [0:31];
    logic        got_last [0:31];
    vec_t        vecs [6];
    int          n_cmp;
    int          n_bad;
    int          first_cyc;

    matmul_drain #(.A(2), .C(3), .OUT_BITS(32), .Q_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .shift      (shift),
        .m3_rd_addr (m3_rd_addr),
        .m3_rd_data (m3_rd_data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    assign m3_rd_data = mem[m3_rd_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_last"}, 32'(out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_addr"}, 32'(m3_rd_addr), 32'd0);
    endtask

    // One pass; outputs observed at negedge, ready driven for the coming edge.
    task automatic run_pass(input int ready_mode, input int start_mode, output int nb, output int done_cyc);
        int cyc;
        logic pv, pr, pl;
        logic [31:0] pd;
        nb = 0; done_cyc = -1; first_cyc = -1; cyc = 0;
        pv = 1'b0; pr = 1'b1; pd = 32'd0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        while (done_cyc < 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = (start_mode == 1) ? ((cyc % 2) == 0) : 1'b0;
            if (cyc == 1) begin
                check("busy_after_accept", 32'(busy), 32'd1);
                check("addr_after_accept", 32'(m3_rd_addr), 32'd0);
            end
            if (pv && !pr) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), pd);
                check("stall_last", 32'(out_last), 32'(pl));
            end
            out_ready = (ready_mode == 0) ? 1'b1 : ((((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3));
            if (out_valid && out_ready && nb < 32) begin
                if (nb == 0) first_cyc = cyc;
                got_data[nb] = 32'(out_data);
                got_last[nb] = out_last;
                nb++;
            end
            if (done) begin
                done_cyc = cyc;
                start = 1'b0;
                check("busy_low_with_done", 32'(busy), 32'd0);
            end
            pv = out_valid; pr = out_ready; pd = 32'(out_data); pl = out_last;
        end
        check("done_seen", 32'(done_cyc >= 0), 32'd1);
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int offset);
        for (int i = 0; i < 6; i++) begin
            check({tag, "_data"}, got_data[offset + i], exp_data[i]);
            check({tag, "_last"}, 32'(got_last[offset + i]), 32'(i == 5));
        end
    endtask

    initial begin
        int nb, dc, cyc, n_done, d1, d2;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; start = 1'b0; shift = 5'd0; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = 32'(i);
        for (int i = 0; i < 6; i++) exp_data[i] = 32'(i);
`ifdef MATMUL_DRAIN_REQUANT_EN
        vecs[0] = '{32'h0000_0100, 8'h10};
        vecs[1] = '{32'h0000_0018, 8'h02};
        vecs[2] = '{32'h0000_1000, 8'h7F};
        vecs[3] = '{32'hFFFF_F000, 8'h80};
        vecs[4] = '{32'hFFFF_FFF8, 8'h00};
        vecs[5] = '{32'hFFFF_FF7F, 8'hF8};
`else
        vecs[0] = '{32'h8000_0000, 32'h8000_0000};
        vecs[1] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        vecs[2] = '{32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{32'h0000_0001, 32'h0000_0001};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[5] = '{32'h1234_5678, 32'h1234_5678};
`endif
        #12;
        check_outputs_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("idle");

        // Free-flowing sink: first beat 3 cycles after start is presented, done at 9 (L+3).
        run_pass(0, 0, nb, dc);
        check("flow_beats", 32'(nb), 32'd6);
        check_seq("flow", 0);
        check("flow_first_beat_cyc", 32'(first_cyc), 32'd3);
        check("flow_done_cyc", 32'(dc), 32'd9);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);

        // Sink ready pattern 1,0,0,1: same words, no duplicates or drops.
        run_pass(1, 0, nb, dc);
        check("bp_beats", 32'(nb), 32'd6);
        check_seq("bp", 0);

        // Stray start pulses during the pass are ignored.
        run_pass(0, 1, nb, dc);
        check("stray_beats", 32'(nb), 32'd6);
        check_seq("stray", 0);
        check("stray_done_cyc", 32'(dc), 32'd9);
        repeat (3) @(negedge clk);
        check("stray_no_restart", 32'(busy), 32'd0);

        // Asynchronous reset on beat 3, then a clean restart.
        @(negedge clk);
        start = 1'b1; nb = 0; cyc = 0;
        while (nb < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (out_valid && out_ready) nb++;
        end
        check("rst_reached_beat3", 32'(nb), 32'd3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_pass(0, 0, nb, dc);
        check("after_rst_beats", 32'(nb), 32'd6);
        check_seq("after_rst", 0);
        check("after_rst_done_cyc", 32'(dc), 32'd9);

        // Start held high: back-to-back passes, each from address 0, accepted every L+4 cycles.
        @(negedge clk);
        start = 1'b1; nb = 0; cyc = 0; n_done = 0; d1 = 0; d2 = 0;
        while (n_done < 2 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (out_valid && out_ready && nb < 32) begin
                got_data[nb] = 32'(out_data);
                got_last[nb] = out_last;
                nb++;
            end
            if (done) begin
                n_done++;
                if (n_done == 1) d1 = cyc; else d2 = cyc;
            end
        end
        start = 1'b0;
        check("hold_done_count", 32'(n_done), 32'd2);
        check("hold_beats", 32'(nb), 32'd12);
        check_seq("hold_pass1", 0);
        check_seq("hold_pass2", 6);
        check("hold_done_spacing", 32'(d2 - d1), 32'd10);
        repeat (3) @(negedge clk);

        // Word table: requantized with shift 4, or passed through when requant is off.
        for (int i = 0; i < 6; i++) mem[i] = vecs[i].word;
        shift = 5'd4;
        run_pass(0, 0, nb, dc);
        check("table_beats", 32'(nb), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check("table_word", got_data[i], 32'(vecs[i].exp));
        end
        shift = 5'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/matmul_drain.md
# matmul_drain

Downstream consumer of the matmul_n result RAM. Once the multiplier raises `valid`, this block walks the A×C output block_ram in row-major address order and streams every element out on a valid/ready interface. Read-latency and backpressure are absorbed by a 2-entry skid buffer, so the stream runs at one element per cycle whenever the sink is ready. An optional requantizer narrows each 32-bit accumulator to a saturated signed byte.

## Interface
- `A`, 16, rows of result matrix
- `C`, 24, columns of result matrix
- `OUT_BITS`, 32, result RAM word width (signed two's complement)
- `Q_BITS`, 8, requantized output width
- `L` (derived), A*C, element count; address width `$clog2(L)`
- `OUT_W` (derived), `Q_BITS` when `MATMUL_DRAIN_REQUANT_EN` is defined, else `OUT_BITS`
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  level; sampled only in IDLE; tie to matmul_n `valid`
- `shift`  in  5  requant right-shift amount; must be held stable while `busy`
- `m3_rd_addr`  out  `$clog2(L)`  result RAM read address (registered)
- `m3_rd_data`  in  `OUT_BITS`  RAM read data, valid one cycle after the address
- `out_data`  out  `OUT_W`  stream payload
- `out_valid`  out  1  payload valid
- `out_ready`  in  1  sink accepts when high
- `out_last`  out  1  high with element L-1
- `busy`  out  1  high from the start accept until done
- `done`  out  1  one-cycle pulse after the final handshake

## Operation
- FSM states: IDLE, STREAM, DONE.
  - IDLE→STREAM when `start`=1.
  - STREAM→DONE on the handshake (`out_valid`&`out_ready`) of element L-1.
  - DONE→IDLE unconditionally after one cycle.
- Read issue: a read issues in STREAM when `issued < L` and `fifo_count + inflight < 2`.
  - `inflight` is 0 or 1 (one-cycle RAM latency).
  - Each issue drives `m3_rd_addr` and increments the address. The address stays at its last value after L-1 and does not wrap.
- The returning word is written into the 2-entry FIFO one cycle after issue. The credit rule means the FIFO never overflows and data is never dropped.
- The FIFO head drives `out_data`/`out_valid`. `out_last` = head tag (address == L-1).
- Handshake rules:
  - Once `out_valid` rises, `out_data`, `out_last` and `out_valid` hold until the handshake.
  - `out_valid` never depends combinationally on `out_ready`.
- `start` while busy or in DONE is ignored. A re-armed `start` in the cycle after DONE begins a new pass from address 0.
- Async reset mid-operation returns to IDLE, empties the FIFO and zeroes the counters. Partial output is abandoned.
- Reset values: `m3_rd_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.

## Timing
- `start` is sampled at edge E0. `busy`=1 and `m3_rd_addr`=0 from E0.
- Data for address 0 reaches the FIFO at E2. The earliest `out_valid` is the cycle after E2.
- With `out_ready` tied high: one element per cycle, all L elements in consecutive cycles, `out_last` on the L-th.
- `done` pulses the cycle after the last handshake. `busy` drops together with `done`.
- Total with no backpressure: L+3 cycles from start accept to `done`.
- Backpressure of any length causes at most 2 buffered words plus 0 in flight. Issue resumes in the cycle after the first pop.
- Requantization is combinational on `m3_rd_data` before the FIFO write and adds no latency.

## Configuration
- `MATMUL_DRAIN_REQUANT_EN` defined:
  - `out_data` is `Q_BITS` wide.
  - Value = saturate_signed_Q_BITS((x + (shift>0 ? 1<<(shift-1) : 0)) >>> shift).
  - The rounding add is computed at `OUT_BITS+1` bits to avoid overflow.
  - Saturation limits are 0x7F and 0x80 for 8 bits.
- Not defined: `out_data` = `m3_rd_data` unmodified (`OUT_BITS`) and `shift` is ignored.

## Test plan
- Use A=2, C=3, RAM preloaded 0..5, `out_ready`=1, `start` pulse → 6 beats carrying 0,1,2,3,4,5, `out_last` on beat 6, `done` 9 cycles after start accept.
- Same RAM, `out_ready` toggling 1,0,0,1 repeating → identical sequence with no duplicates or drops. `out_data`/`out_valid` hold during every stall and FIFO occupancy is never above 2.
- Requant enabled, shift=4, words 0x100, 0x18, 0x1000, 0xFFFFF000, 0xFFFFFFF8 → 0x10, 0x02, 0x7F, 0x80, 0x00.
- Requant disabled, words 0x80000000 and 0x7FFFFFFF → passed through unchanged.
- Assert `rst_n`=0 at beat 3 of a run → all outputs 0 immediately. Next `start` restarts at address 0 and delivers the full 6 beats.
- `start` held high continuously → back-to-back passes, each beginning at address 0. `start` pulses during STREAM do not perturb the running pass.
